mem_port_arbiter: RTL and testbench

Sequences the single shared memory port between the instruction-fetch stage (IF) and the data-memory stage (DM) of the five-stage pipeline. It grants one requester at a time and drives the select of the 32-bit 2:1 address/data muxes in front of the memory (sel=0 picks the IF input, sel=1 picks the DM input). It runs the memory valid/ready handshake, produces per-requester done pulses and stall signals, prevents fetch starvation, and aborts hung accesses with a watchdog.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and DM.
// Grants one requester per access, guards fetch starvation, aborts hung accesses.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic dm_req,
  input  logic mem_ready,
  output logic sel,
  output logic mem_valid,
  output logic if_gnt,
  output logic dm_gnt,
  output logic if_done,
  output logic dm_done,
  output logic if_err,
  output logic dm_err,
  output logic if_stall,
  output logic dm_stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BIF  = 2'd1,
    S_BDM  = 2'd2
  } state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [7:0] TMO_LAST =
    (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t r_state;
  state_t w_next;
  logic       r_sel;
  logic [3:0] r_starve;
  logic [7:0] r_wait;
  logic       w_idle;
  logic       w_tmo;
  logic       w_pick_dm;
  logic       w_pick_if;

  assign w_idle = (r_state == S_IDLE);

  // DM wins unless IF is waiting and DM already had its streak
  assign w_pick_dm = dm_req & (~if_req | (r_starve < LIM));
  assign w_pick_if = if_req & ~w_pick_dm;

  // watchdog fires only when memory is still silent on the last allowed cycle
  assign w_tmo = TMO_EN & ~w_idle & ~mem_ready
               & (r_wait == TMO_LAST);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state: every access returns through IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_dm)      w_next = S_BDM;
        else if (w_pick_if) w_next = S_BIF;
      end
      S_BIF, S_BDM: begin
        if (mem_ready || w_tmo) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // output decode of the current state
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    unique case (r_state)
      S_BIF:   if_gnt = 1'b1;
      S_BDM:   dm_gnt = 1'b1;
      default: ;
    endcase
  end

  assign mem_valid = if_gnt | dm_gnt;
  assign if_done   = if_gnt & mem_ready;
  assign dm_done   = dm_gnt & mem_ready;
  assign if_err    = if_gnt & w_tmo;
  assign dm_err    = dm_gnt & w_tmo;
  assign if_stall  = if_req & ~if_done;
  assign dm_stall  = dm_req & ~dm_done;
  assign sel       = r_sel;

  // mux select changes only on a grant decision, so it is stable while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= 1'b0;
    end else if (w_idle) begin
      if (w_pick_dm)      r_sel <= 1'b1;
      else if (w_pick_if) r_sel <= 1'b0;
    end
  end

  // count DM grants taken over a waiting IF; an IF grant clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 4'd0;
    end else if (w_idle) begin
      if (w_pick_dm && if_req)
        r_starve <= (r_starve < LIM) ? r_starve + 4'd1 : LIM;
      else if (w_pick_if)
        r_starve <= 4'd0;
    end
  end

  // wait-cycle counter, zero on the first busy cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= 8'd0;
    end else if (w_idle) begin
      r_wait <= 8'd0;
    end else if (!mem_ready && r_wait != 8'hFF) begin
      r_wait <= r_wait + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed reset checks, then randomized accesses
// scored against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  localparam int SL   = 4;
  localparam int TO   = 8;
  localparam int NACC = 120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_req = 1'b0;
  logic dm_req = 1'b0;
  logic mem_ready = 1'b0;
  logic sel, mem_valid, if_gnt, dm_gnt;
  logic if_done, dm_done, if_err, dm_err;
  logic if_stall, dm_stall;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit dm;
    bit err;
    int n;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit   mon_en = 1'b0;
  int   bcnt = 0;
  logic [3:0] ev;
  logic [3:0] pulses;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .STARVE_LIMIT(SL),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_req(if_req),
    .dm_req(dm_req),
    .mem_ready(mem_ready),
    .sel(sel),
    .mem_valid(mem_valid),
    .if_gnt(if_gnt),
    .dm_gnt(dm_gnt),
    .if_done(if_done),
    .dm_done(dm_done),
    .if_err(if_err),
    .dm_err(dm_err),
    .if_stall(if_stall),
    .dm_stall(dm_stall)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: every busy cycle is matched against the head of the queue
  always @(negedge clk) begin
    pulses = {if_done, dm_done, if_err, dm_err};
    if (!mon_en) begin
      bcnt = 0;
    end else if (mem_valid) begin
      bcnt++;
      if (q.size() == 0) begin
        chk("unexpected_grant", {30'd0, if_gnt, dm_gnt}, 32'd0);
      end else begin
        e = q[0];
        chk("sel", {31'd0, sel}, {31'd0, e.dm});
        chk("gnt", {30'd0, if_gnt, dm_gnt}, {30'd0, !e.dm, e.dm});
        if (pulses != 4'd0 || bcnt >= e.n) begin
          ev = {!e.dm && !e.err, e.dm && !e.err,
                !e.dm && e.err, e.dm && e.err};
          chk("term", {28'd0, pulses}, {28'd0, ev});
          chk("busy_len", bcnt, e.n);
          chk("stall", {30'd0, if_stall, dm_stall},
              {30'd0, if_req && !ev[3], dm_req && !ev[2]});
          void'(q.pop_front());
          bcnt = 0;
        end
      end
    end else begin
      chk("spurious_pulse", {28'd0, pulses}, 32'd0);
      bcnt = 0;
    end
  end

  initial begin
    bit w_dm;
    bit drop;
    bit err;
    int lat;
    int n;
    int streak;
    int lats[7];
    lats = '{0, 0, 1, 2, 3, TO - 1, TO + 3};
    streak = 0;

    dm_req = 1'b1;
    #1;
    chk("rst_outs",
        {24'd0, sel, mem_valid, if_gnt, dm_gnt,
         if_done, dm_done, if_err, dm_err}, 32'd0);
    chk("rst_stall", {30'd0, if_stall, dm_stall}, 32'd1);
    dm_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    dm_req = 1'b1;
    @(posedge clk); #1;
    chk("dm_grant", {29'd0, sel, mem_valid, dm_gnt}, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {29'd0, sel, mem_valid, dm_gnt}, 32'd0);
    dm_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if_req = 1'b1;
    @(posedge clk); #1;
    chk("if_after_rst", {29'd0, sel, mem_valid, if_gnt}, 32'd3);
    mem_ready = 1'b1;
    #1;
    chk("if_done_dir", {30'd0, if_done, if_stall}, 32'd2);
    @(posedge clk); #1;
    if_req = 1'b0;
    mem_ready = 1'b0;
    chk("idle_after", {31'd0, mem_valid}, 32'd0);
    mon_en = 1'b1;

    for (int k = 0; k < NACC; ) begin
      if (k < 4) begin
        if_req = 1'b1;
      end else if (k < 16) begin
        if_req = 1'b1;
        dm_req = 1'b1;
      end else begin
        if (!if_req && ($urandom % 2 == 0)) if_req = 1'b1;
        if (!dm_req && ($urandom % 2 == 0)) dm_req = 1'b1;
      end
      mem_ready = 1'($urandom % 2);
      if (!if_req && !dm_req) begin
        @(posedge clk); #1;
        continue;
      end

      w_dm = dm_req && !(if_req && streak >= SL);
      if (w_dm && if_req) streak++;
      else if (!w_dm) streak = 0;

      lat  = (k < 16) ? 0 : lats[$urandom % 7];
      err  = (lat >= TO);
      n    = err ? TO : lat + 1;
      drop = (k >= 16) && ($urandom % 5 == 0);
      q.push_back('{dm: w_dm, err: err, n: n});

      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
        mem_ready = (i == lat);
        if (i == 0 && drop) begin
          if (w_dm) dm_req = 1'b0;
          else      if_req = 1'b0;
        end
        @(posedge clk); #1;
      end
      if (w_dm) dm_req = 1'b0;
      else      if_req = 1'b0;
      k++;
    end

    if_req = 1'b0;
    dm_req = 1'b0;
    mem_ready = 1'b0;
    for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
    chk("drain", q.size(), 32'd0);
    @(posedge clk); #1;
    chk("final_idle", {31'd0, mem_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
